tap_delay_line: RTL and testbench
=================================

# tap_delay_line

Parametrised WIDTH-bit × TAPS-deep shift-register delay line feeding the convolution multiplier's tap products. Each accepted input sample shifts into tap 0 and every older sample moves one tap deeper, so all TAPS samples are presented in parallel. Fill tracking reports when the window holds TAPS valid samples, and a per-sample output strobe tells the downstream multiply-accumulate when a full window is ready. It generalises the fixed 32-bit register in width and depth, and adds enable, flush, fill and strobe behaviour.

## Interface
- WIDTH, 32, bits per sample/tap (≥1)
- TAPS, 4, number of delay stages (≥2)
- CNT_W, $clog2(TAPS+1), fill-counter width (derived, not overridden)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- clear  input  1  synchronous flush, same effect as rst
- in_valid  input  1  in_data is offered and accepted this cycle
- in_data  input  WIDTH  sample
- hold  input  1  freeze shifting (present only with TAP_DELAY_HOLD_EN)
- taps  output  WIDTH*TAPS  tap k at bits [k*WIDTH +: WIDTH]; tap 0 is newest
- fill_count  output  CNT_W  valid samples held, saturates at TAPS
- window_valid  output  1  fill_count == TAPS
- out_valid  output  1  one-cycle strobe: a new full window is on taps

## Operation
- accept = in_valid & ~hold; without the macro, hold is treated as 0.
- Priority per edge: rst > clear > accept > idle.
- rst or clear: all taps ← 0; fill_count ← 0; window_valid ← 0; out_valid ← 0. A sample offered in the same cycle is dropped.
- On accept: tap0 ← in_data; tapk ← tap(k-1) for k = 1..TAPS-1; tap(TAPS-1) old value is discarded. fill_count ← min(fill_count+1, TAPS).
- Idle (no accept): taps and fill_count hold; out_valid ← 0.
- Two implicit states: FILLING (fill_count < TAPS) and FULL (fill_count == TAPS).
  - FILLING → FULL on the accept that makes fill_count == TAPS.
  - FULL → FILLING only via rst/clear.
- out_valid ← accept & (fill_count ≥ TAPS-1), using the pre-edge fill_count.
- window_valid is registered and equals (fill_count == TAPS) after each edge.
- No arithmetic on data; taps are a pure copy. The counter never wraps.

## Timing
- Reset values: taps = 0, fill_count = 0, window_valid = 0, out_valid = 0.
- Latency: a sample accepted at edge N appears on tap0 after edge N and on tapk after k further accepts.
- out_valid is high for exactly the cycle after each accepted sample while FULL (including the filling accept), and low otherwise. Back-to-back accepts in FULL give a continuous strobe.
- No ready/backpressure: every in_valid not blocked by hold is consumed in that cycle.
- Reset or clear mid-fill or mid-stream takes effect at that edge; the next accept restarts at fill_count = 1.

## Configuration
- TAP_DELAY_HOLD_EN defined: the hold port exists. hold = 1 blocks shifting and fill counting, and forces out_valid ← 0, even when in_valid = 1. rst and clear still override hold.
- TAP_DELAY_HOLD_EN undefined: no hold port; accept = in_valid.

## Structure
- Package tap_delay_pkg holds:
  - TAP_DELAY_WIDTH_DEF = 32
  - TAP_DELAY_TAPS_DEF = 4
  - typedef tap_fill_state_e {FILLING, FULL}, used for debug/assertions
- Sub-module tap_stage: one WIDTH-bit register with synchronous rst, clear and load enable, generated TAPS times. The counter and strobe live in the top.

## Test plan
Use WIDTH=32, TAPS=4 unless stated.
1. Reset: hold rst 2 cycles, release -> taps all 0, fill_count=0, window_valid=0, out_valid=0.
2. Fill: accept 0x1, 0x2, 0x3, 0x4 on consecutive cycles -> after the 4th edge taps(0..3) = 4,3,2,1, fill_count=4, window_valid=1. out_valid is high only in the cycle after the 4th accept.
3. Stream and gaps: accept 0x5, idle 2 cycles, then accept 0x6 -> taps = 5,4,3,2, then unchanged with out_valid=0 while idle, then 6,5,4,3 with out_valid=1. fill_count stays 4.
4. Clear collision: in FULL, assert clear with in_valid=1 and in_data=0x9 -> taps 0, fill_count 0, out_valid 0, and 0x9 absent. Next accept 0xA gives tap0=0xA, fill_count=1.
5. Mid-fill reset: accept 2 samples, pulse rst -> all outputs 0. Four more accepts are then required before out_valid.
6. Hold (TAP_DELAY_HOLD_EN): in FULL, hold=1 with in_valid=1 and in_data=0x7 -> taps and fill_count unchanged, out_valid=0. Release hold -> 0x7 accepted on the next valid cycle.

Source files
------------

// File: rtl/tap_delay_pkg.sv
// Shared constants and fill-state type for the tap delay line.
package tap_delay_pkg;

    localparam int TAP_DELAY_WIDTH_DEF = 32;
    localparam int TAP_DELAY_TAPS_DEF  = 4;

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } tap_fill_state_e;

endpackage

// File: rtl/tap_delay_line_if.sv
// Sample/tap bundle for tap_delay_line; the hold port exists only when
// TAP_DELAY_HOLD_EN is defined.
interface tap_delay_line_if
    import tap_delay_pkg::*;
#(
    parameter int WIDTH = TAP_DELAY_WIDTH_DEF,
    parameter int TAPS  = TAP_DELAY_TAPS_DEF
);
    localparam int CNT_W = $clog2(TAPS + 1);

    logic                  clear;
    logic                  in_valid;
    logic [WIDTH-1:0]      in_data;
`ifdef TAP_DELAY_HOLD_EN
    logic                  hold;
`endif
    logic [WIDTH*TAPS-1:0] taps;
    logic [CNT_W-1:0]      fill_count;
    logic                  window_valid;
    logic                  out_valid;

    modport master (
`ifdef TAP_DELAY_HOLD_EN
        output hold,
`endif
        output clear, in_valid, in_data,
        input  taps, fill_count, window_valid, out_valid
    );

    modport slave (
`ifdef TAP_DELAY_HOLD_EN
        input  hold,
`endif
        input  clear, in_valid, in_data,
        output taps, fill_count, window_valid, out_valid
    );

endinterface

// File: rtl/tap_stage.sv
// One delay-line register: synchronous rst/clear to zero, otherwise loads d when load is set.
module tap_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tap_delay_line.sv
// WIDTH x TAPS shift-register delay line with fill tracking and full-window strobe.
// Optional hold input enabled by defining TAP_DELAY_HOLD_EN.
module tap_delay_line
    import tap_delay_pkg::*;
#(
    parameter int WIDTH = TAP_DELAY_WIDTH_DEF,
    parameter int TAPS  = TAP_DELAY_TAPS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    tap_delay_line_if.slave bus
);

    localparam int               CNT_W    = $clog2(TAPS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

    logic                  accept;
    logic [WIDTH-1:0]      tap_q [TAPS];
    logic [WIDTH*TAPS-1:0] taps_flat;

    tap_fill_state_e  state_q, state_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             out_vld_q, out_vld_d;

`ifdef TAP_DELAY_HOLD_EN
    assign accept = bus.in_valid & ~bus.hold;
`else
    assign accept = bus.in_valid;
`endif

    // Tap 0 takes the new sample; each deeper tap takes its shallower neighbour.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic [WIDTH-1:0] d;
        if (k == 0) begin : g_head
            assign d = bus.in_data;
        end else begin : g_body
            assign d = tap_q[k-1];
        end

        tap_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clear (bus.clear),
            .load  (accept),
            .d     (d),
            .q     (tap_q[k])
        );
    end

    always_comb begin
        taps_flat = '0;
        for (int k = 0; k < TAPS; k++) begin
            taps_flat[k*WIDTH +: WIDTH] = tap_q[k];
        end
    end

    // Strobe uses the pre-edge count so the filling accept also fires it.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        out_vld_d  = 1'b0;
        if (accept) begin
            out_vld_d = (fill_cnt_q >= LAST_CNT);
            if (fill_cnt_q != FULL_CNT) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
            if (fill_cnt_q >= LAST_CNT) begin
                state_d = FULL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state_q    <= FILLING;
            fill_cnt_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign bus.taps         = taps_flat;
    assign bus.fill_count   = fill_cnt_q;
    assign bus.window_valid = (state_q == FULL);
    assign bus.out_valid    = out_vld_q;

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line: directed scenarios plus random traffic against a queue model.
module tb_tap_delay_line;

    localparam int WIDTH = 32;
    localparam int TAPS  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] mq[$];
    logic             exp_ov = 1'b0;

    tap_delay_line_if #(.WIDTH(WIDTH), .TAPS(TAPS)) bus ();

    tap_delay_line #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Newest accepted sample sits at the queue front; the queue never exceeds TAPS entries.
    task automatic model_update(input logic v, input logic [WIDTH-1:0] d,
                                input logic c, input logic r, input logic h);
        if (r || c) begin
            mq.delete();
            exp_ov = 1'b0;
        end else if (v && !h) begin
            exp_ov = (mq.size() >= TAPS - 1);
            mq.push_front(d);
            if (mq.size() > TAPS) void'(mq.pop_back());
        end else begin
            exp_ov = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [127:0] exp_taps;
        exp_taps = '0;
        for (int i = 0; i < mq.size(); i++) exp_taps[i*WIDTH +: WIDTH] = mq[i];
        check_eq({tag, ".taps"},   128'(bus.taps),         exp_taps);
        check_eq({tag, ".fill"},   128'(bus.fill_count),   128'(mq.size()));
        check_eq({tag, ".window"}, 128'(bus.window_valid), 128'(mq.size() == TAPS));
        check_eq({tag, ".ovld"},   128'(bus.out_valid),    128'(exp_ov));
    endtask

    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                        input logic c, input logic r, input logic h);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        rst          = r;
`ifdef TAP_DELAY_HOLD_EN
        bus.hold     = h;
`endif
        @(posedge clk);
        model_update(v, d, c, r, h);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clear    = 1'b0;
`ifdef TAP_DELAY_HOLD_EN
        bus.hold     = 1'b0;
`endif

        step("rst0", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step("rst1", 1'b1, 32'hdead, 1'b0, 1'b1, 1'b0);
        step("idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 1; i <= 4; i++) step($sformatf("fill%0d", i), 1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);

        step("acc5",  1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        step("gap0",  1'b0, 32'hff, 1'b0, 1'b0, 1'b0);
        step("gap1",  1'b0, 32'hee, 1'b0, 1'b0, 1'b0);
        step("acc6",  1'b1, 32'h6, 1'b0, 1'b0, 1'b0);

        step("clr9",  1'b1, 32'h9, 1'b1, 1'b0, 1'b0);
        step("accA",  1'b1, 32'hA, 1'b0, 1'b0, 1'b0);

        step("mid1",  1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step("mrst",  1'b1, 32'h12, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step($sformatf("refill%0d", i), 1'b1, WIDTH'(32'h20 + i), 1'b0, 1'b0, 1'b0);

`ifdef TAP_DELAY_HOLD_EN
        step("hold7", 1'b1, 32'h7, 1'b0, 1'b0, 1'b1);
        step("hold7b", 1'b1, 32'h7, 1'b0, 1'b0, 1'b1);
        step("rel7",  1'b1, 32'h7, 1'b0, 1'b0, 1'b0);
        step("hclr",  1'b1, 32'h8, 1'b1, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic v, c, r, h;
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 31) == 0);
            r = ($urandom_range(0, 63) == 0);
`ifdef TAP_DELAY_HOLD_EN
            h = ($urandom_range(0, 7) == 0);
`else
            h = 1'b0;
`endif
            step($sformatf("rnd%0d", i), v, $urandom(), c, r, h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
